// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mux_rr_arbiter_pkg
//  Purpose  : Shared definitions for the round-robin mux arbiter: select
//             width, requester count, reset pointer, select encodings and
//             a select-to-one-hot helper.
//  Revision : 1.0 - initial release
// ============================================================================
package mux_rr_arbiter_pkg;

  // Select width and requester count of the shared 4:1 datapath
  localparam int SEL_W   = 2;
  localparam int REQ_CNT = 4;

  // Round-robin pointer value after reset: requester 0 has priority first
  localparam logic [SEL_W-1:0] PTR_RST = 2'd0;

  // Select encodings of the four mux inputs
  localparam logic [SEL_W-1:0] SEL_IN0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_IN1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_IN2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_IN3 = 2'd3;

  // Convert a select index into a one-hot requester vector
  function automatic logic [REQ_CNT-1:0] sel2onehot(input logic [SEL_W-1:0] sel);
    return REQ_CNT'(1) << sel;
  endfunction

endpackage : mux_rr_arbiter_pkg
`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_arbiter_rr_pick
//  Purpose  : Combinational round-robin picker. Returns the first set
//             request bit searching upward from ptr_i, wrapping 3 -> 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter_rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [REQ_CNT-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [SEL_W-1:0]   winner_o,
  output logic               any_o
);

  logic [SEL_W-1:0] w_idx;

  // Scan from the farthest offset down to ptr_i so the nearest request wins
  always_comb begin
    winner_o = ptr_i;
    w_idx    = ptr_i;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      w_idx = ptr_i + SEL_W'(k);
      if (req_i[w_idx]) begin
        winner_o = w_idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule : mux_rr_arbiter_rr_pick
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_arbiter
//  Purpose  : Round-robin arbiter sharing a 4:1 W-bit mux between four
//             requesters. The chosen word is captured into an output
//             register presented with valid/ready; the winner receives a
//             one-cycle combinational grant in the capture cycle.
//  Options  : MUX_ARB_LOCK_EN - adds the per-requester burst 'lock' input.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int W     = 4,
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_CNT-1:0]   req,
  input  logic [W-1:0]         in0,
  input  logic [W-1:0]         in1,
  input  logic [W-1:0]         in2,
  input  logic [W-1:0]         in3,
`ifdef MUX_ARB_LOCK_EN
  input  logic [REQ_CNT-1:0]   lock,
`endif
  output logic [REQ_CNT-1:0]   gnt,
  output logic [SEL_W-1:0]     out_sel,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // The select path is 2 bits wide; only four requesters are supported
  generate
    if (N_REQ != REQ_CNT) begin : g_bad_n_req
      $error("mux_rr_arbiter: N_REQ must be 4");
    end
  endgenerate

  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] w_rr_winner;
  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_slot_free;
  logic             w_capture;
  logic             w_lock_hit;
  logic [W-1:0]     w_mux_data;

  mux_rr_arbiter_rr_pick u_rr_pick (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .winner_o (w_rr_winner),
    .any_o    (w_any)
  );

`ifdef MUX_ARB_LOCK_EN
  // Remembers whether any capture has happened since reset, so that the
  // reset value of out_sel is never mistaken for a locked last winner
  logic last_vld_q;

  // Track existence of a previous winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld_q <= 1'b0;
    end else if (w_capture) begin
      last_vld_q <= 1'b1;
    end
  end

  // out_sel_q always holds the most recent winner
  assign w_lock_hit = last_vld_q && lock[out_sel_q] && req[out_sel_q];
`else
  assign w_lock_hit = 1'b0;
`endif

  assign w_winner    = w_lock_hit ? out_sel_q : w_rr_winner;
  assign w_slot_free = !out_valid_q || out_ready;
  // No grant may leave the block while reset is asserted
  assign w_capture   = rst_n && w_slot_free && w_any;
  assign gnt         = w_capture ? sel2onehot(w_winner) : '0;

  // Shared 4:1 datapath mux, selected by the next value of out_sel
  always_comb begin
    w_mux_data = in0;
    case (w_winner)
      SEL_IN0: w_mux_data = in0;
      SEL_IN1: w_mux_data = in1;
      SEL_IN2: w_mux_data = in2;
      SEL_IN3: w_mux_data = in3;
    endcase
  end

  // Next-state: capture, drain on accept, or hold on stall
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (w_capture) begin
      out_data_d  = w_mux_data;
      out_sel_d   = w_winner;
      out_valid_d = 1'b1;
      if (!w_lock_hit) begin
        rr_ptr_d = w_winner + 2'd1;
      end
    end else if (w_slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= SEL_IN0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= PTR_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule : mux_rr_arbiter
`default_nettype wire
